dcache_mem_arbiter: RTL and testbench
=====================================

Name: dcache_mem_arbiter

Overview:
- Shares one memory-controller channel between NUM_REQUESTERS data-cache miss/writeback ports.
- Each requester presents a read or write using a valid/ready pair and holds it until ready; the arbiter grants requesters one at a time in round-robin order.
- Sits between the dcache's controller-side ports and the global memory controller; one instance per memory channel.

Parameters:
- ADDR_BITS, 8, address width.
- DATA_BITS, 8, data width.
- NUM_REQUESTERS, 4, number of requester ports (≥2).
- ID_BITS, $clog2(NUM_REQUESTERS), width of grant index.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_read_valid  in  NUM_REQUESTERS  per-requester read request.
- req_read_address  in  ADDR_BITS x NUM_REQUESTERS (unpacked)  read address.
- req_read_ready  out  NUM_REQUESTERS  read done; data valid.
- req_read_data  out  DATA_BITS x NUM_REQUESTERS (unpacked)  read data.
- req_write_valid  in  NUM_REQUESTERS  per-requester write request.
- req_write_address  in  ADDR_BITS x NUM_REQUESTERS  write address.
- req_write_data  in  DATA_BITS x NUM_REQUESTERS  write data.
- req_write_ready  out  NUM_REQUESTERS  write done.
- mem_read_valid  out  1  read request to memory.
- mem_read_address  out  ADDR_BITS  read address.
- mem_read_ready  in  1  memory read done.
- mem_read_data  in  DATA_BITS  memory read data.
- mem_write_valid  out  1  write request to memory.
- mem_write_address  out  ADDR_BITS  write address.
- mem_write_data  out  DATA_BITS  write data.
- mem_write_ready  in  1  memory write done.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  ID_BITS  index of the current or last granted requester.

Behaviour:
- Reset (async, any time, including mid-transaction):
  - state=IDLE, rr_ptr=0, grant_id=0.
  - All outputs 0: every ready bit, every req_read_data entry, all mem_* outputs, busy.
  - An in-flight memory transaction is abandoned.
- FSM states: IDLE, READ_WAITING, WRITE_WAITING, READ_RELEASE, WRITE_RELEASE.
- IDLE:
  - Scan i = rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQUESTERS.
  - The first i with req_read_valid[i] or req_write_valid[i] wins.
  - If both bits are set on the winner, the read wins; its write stays pending for a later grant.
  - On a read win: latch address, set grant_id=i, drive mem_read_valid=1, go to READ_WAITING.
  - On a write win: latch address and data, set grant_id=i, drive mem_write_valid=1, go to WRITE_WAITING.
  - Grant is registered: mem valid rises the cycle after the request is first seen.
  - No request pending: stay in IDLE.
- READ_WAITING:
  - Hold mem_read_valid and mem_read_address stable until mem_read_ready=1.
  - That cycle: mem_read_valid←0, req_read_data[grant_id]←mem_read_data, req_read_ready[grant_id]←1, go to READ_RELEASE.
- WRITE_WAITING: same as READ_WAITING using the mem_write_* signals and req_write_ready; no data is returned.
- READ_RELEASE / WRITE_RELEASE:
  - Hold ready high until the granted requester's matching valid is 0.
  - Then ready←0, rr_ptr←(grant_id+1) mod NUM_REQUESTERS, go to IDLE.
  - If valid was already low on entry, ready is high for exactly 1 cycle.
- Requester drops valid while in a WAITING state: the memory transaction still completes and the normal release sequence follows. No abort.
- Latched address/data are immune to requester input changes after the grant.
- req_read_data[i] holds its last value until overwritten; only the granted entry is updated.
- At most one mem valid is high at any time; mem_read_valid and mem_write_valid are never high together.
- Fairness: every requester with valid held high is granted within NUM_REQUESTERS grants.
- Minimum turnaround per transaction: 4 cycles (grant, mem ready, release, idle) with zero-wait memory.

Test Plan:
- Reset, then idle → all outputs 0, busy=0, grant_id=0.
- Single read: requester 2 reads 0x3C, memory returns 0xA5 after 3 cycles → mem_read_address=0x3C from cycle+1; req_read_ready[2]=1 with req_read_data[2]=0xA5; ready drops the cycle after valid drops; rr_ptr=3.
- Single write: requester 1 writes 0x77 to 0x10 → mem_write_address=0x10, mem_write_data=0x77; req_write_ready[1] pulses; no read activity.
- Round-robin: all 4 requesters hold read valid from reset → grant order 0,1,2,3,0; no requester granted twice before the others are served.
- Read+write same port: requester 0 asserts both at once → read served first, then write on the next grant of port 0 (after ports 1–3 if they are pending).
- Reset mid-operation: assert reset in READ_WAITING with mem_read_ready still low → mem_read_valid=0 immediately, state IDLE; after release, re-request is granted normally starting from requester 0.

Source files
------------

// File: rtl/dcache_mem_arbiter.sv
// Round-robin arbiter sharing one memory-controller channel between several
// dcache miss/writeback ports; one transaction in flight at a time.
module dcache_mem_arbiter #(
    parameter int ADDR_BITS      = 8,
    parameter int DATA_BITS      = 8,
    parameter int NUM_REQUESTERS = 4,
    parameter int ID_BITS        = $clog2(NUM_REQUESTERS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQUESTERS-1:0] req_read_valid,
    input  logic [ADDR_BITS-1:0]      req_read_address [NUM_REQUESTERS],
    output logic [NUM_REQUESTERS-1:0] req_read_ready,
    output logic [DATA_BITS-1:0]      req_read_data [NUM_REQUESTERS],
    input  logic [NUM_REQUESTERS-1:0] req_write_valid,
    input  logic [ADDR_BITS-1:0]      req_write_address [NUM_REQUESTERS],
    input  logic [DATA_BITS-1:0]      req_write_data [NUM_REQUESTERS],
    output logic [NUM_REQUESTERS-1:0] req_write_ready,
    output logic                      mem_read_valid,
    output logic [ADDR_BITS-1:0]      mem_read_address,
    input  logic                      mem_read_ready,
    input  logic [DATA_BITS-1:0]      mem_read_data,
    output logic                      mem_write_valid,
    output logic [ADDR_BITS-1:0]      mem_write_address,
    output logic [DATA_BITS-1:0]      mem_write_data,
    input  logic                      mem_write_ready,
    output logic                      busy,
    output logic [ID_BITS-1:0]        grant_id
);

    typedef enum logic [2:0] {
        IDLE, READ_WAITING, WRITE_WAITING, READ_RELEASE, WRITE_RELEASE
    } state_t;

    state_t               state, next_state;
    logic [ID_BITS-1:0]   rr_ptr;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0] wdata_q;
    logic                 pick_found, pick_read;
    logic [ID_BITS-1:0]   pick_id;

    function automatic logic [ID_BITS-1:0] wrap_id(input int v);
        return ID_BITS'(v % NUM_REQUESTERS);
    endfunction

    // First requester at or after rr_ptr with any request; read beats write on the same port.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        pick_read  = 1'b0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            if (!pick_found && (req_read_valid[wrap_id(int'(rr_ptr) + k)] ||
                                req_write_valid[wrap_id(int'(rr_ptr) + k)])) begin
                pick_found = 1'b1;
                pick_id    = wrap_id(int'(rr_ptr) + k);
                pick_read  = req_read_valid[pick_id];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:          if (pick_found) next_state = pick_read ? READ_WAITING : WRITE_WAITING;
            READ_WAITING:  if (mem_read_ready) next_state = READ_RELEASE;
            WRITE_WAITING: if (mem_write_ready) next_state = WRITE_RELEASE;
            READ_RELEASE:  if (!req_read_valid[grant_id]) next_state = IDLE;
            WRITE_RELEASE: if (!req_write_valid[grant_id]) next_state = IDLE;
            default:       next_state = IDLE;
        endcase
    end

    always_comb begin
        req_read_ready  = '0;
        req_write_ready = '0;
        if (state == READ_RELEASE)  req_read_ready[grant_id]  = 1'b1;
        if (state == WRITE_RELEASE) req_write_ready[grant_id] = 1'b1;
    end

    assign busy              = (state != IDLE);
    assign mem_read_valid    = (state == READ_WAITING);
    assign mem_write_valid   = (state == WRITE_WAITING);
    assign mem_read_address  = addr_q;
    assign mem_write_address = addr_q;
    assign mem_write_data    = wdata_q;

    // Request fields are captured at grant so later requester changes cannot disturb memory.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr   <= '0;
            grant_id <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            for (int i = 0; i < NUM_REQUESTERS; i++) req_read_data[i] <= '0;
        end else begin
            if (state == IDLE && pick_found) begin
                grant_id <= pick_id;
                addr_q   <= pick_read ? req_read_address[pick_id] : req_write_address[pick_id];
                if (!pick_read) wdata_q <= req_write_data[pick_id];
            end
            if (state == READ_WAITING && mem_read_ready)
                req_read_data[grant_id] <= mem_read_data;
            if ((state == READ_RELEASE || state == WRITE_RELEASE) && next_state == IDLE)
                rr_ptr <= wrap_id(int'(grant_id) + 1);
        end
    end

endmodule

// File: tb/tb_dcache_mem_arbiter.sv
// Bench for dcache_mem_arbiter: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dcache_mem_arbiter;
    localparam int N = 4;
    localparam int A = 8;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req_read_valid, req_read_ready, req_write_valid, req_write_ready;
    logic [A-1:0] req_read_address [N];
    logic [A-1:0] req_write_address [N];
    logic [D-1:0] req_write_data [N];
    logic [D-1:0] req_read_data [N];
    logic         mem_read_valid, mem_read_ready, mem_write_valid, mem_write_ready, busy;
    logic [A-1:0] mem_read_address, mem_write_address;
    logic [D-1:0] mem_read_data, mem_write_data;
    logic [1:0]   grant_id;

    dcache_mem_arbiter #(.ADDR_BITS(A), .DATA_BITS(D), .NUM_REQUESTERS(N)) dut (
        .clk(clk), .reset(reset),
        .req_read_valid(req_read_valid), .req_read_address(req_read_address),
        .req_read_ready(req_read_ready), .req_read_data(req_read_data),
        .req_write_valid(req_write_valid), .req_write_address(req_write_address),
        .req_write_data(req_write_data), .req_write_ready(req_write_ready),
        .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding grant, memory phase then release phase.
    bit           m_active, m_read, m_done;
    int           m_gid, m_ptr;
    logic [A-1:0] m_addr;
    logic [D-1:0] m_wdata;
    logic [D-1:0] m_rdata [N];
    int           grants [$];
    bit           prev_mv;

    function automatic int model_pick();
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (req_read_valid[j] || req_write_valid[j]) return j;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        logic [N-1:0] er, ew;
        int p;
        if (reset) begin
            m_active = 0; m_read = 0; m_done = 0; m_gid = 0; m_ptr = 0;
            m_addr = '0; m_wdata = '0;
            for (int i = 0; i < N; i++) m_rdata[i] = '0;
            chk("rst_mem_read_address", mem_read_address, 0);
            chk("rst_mem_write_address", mem_write_address, 0);
            chk("rst_mem_write_data", mem_write_data, 0);
        end
        er = (m_active && m_read && m_done) ? N'(1) << m_gid : '0;
        ew = (m_active && !m_read && m_done) ? N'(1) << m_gid : '0;
        chk("busy", busy, m_active);
        chk("grant_id", grant_id, m_gid);
        chk("mem_read_valid", mem_read_valid, m_active && m_read && !m_done);
        chk("mem_write_valid", mem_write_valid, m_active && !m_read && !m_done);
        chk("req_read_ready", req_read_ready, er);
        chk("req_write_ready", req_write_ready, ew);
        for (int i = 0; i < N; i++) chk($sformatf("req_read_data[%0d]", i), req_read_data[i], m_rdata[i]);
        if (m_active && m_read && !m_done) chk("mem_read_address", mem_read_address, m_addr);
        if (m_active && !m_read && !m_done) begin
            chk("mem_write_address", mem_write_address, m_addr);
            chk("mem_write_data", mem_write_data, m_wdata);
        end
        if ((mem_read_valid || mem_write_valid) && !prev_mv)
            grants.push_back(int'(grant_id) + (mem_write_valid ? 16 : 0));
        prev_mv = mem_read_valid || mem_write_valid;
        if (!reset) begin
            if (!m_active) begin
                p = model_pick();
                if (p >= 0) begin
                    m_active = 1; m_done = 0; m_gid = p;
                    m_read = req_read_valid[p];
                    m_addr = m_read ? req_read_address[p] : req_write_address[p];
                    if (!m_read) m_wdata = req_write_data[p];
                end
            end else if (!m_done) begin
                if (m_read && mem_read_ready) begin
                    m_rdata[m_gid] = mem_read_data;
                    m_done = 1;
                end else if (!m_read && mem_write_ready) m_done = 1;
            end else if (!(m_read ? req_read_valid[m_gid] : req_write_valid[m_gid])) begin
                m_active = 0;
                m_ptr = (m_gid + 1) % N;
            end
        end
    end

    // Requester and memory behaviour, applied just after each rising edge.
    bit rand_mode = 0;
    bit refill = 0;
    int mem_lat = 2;
    int wait_cnt = 0;

    function automatic int next_lat();
        return rand_mode ? int'($urandom % 4) : mem_lat;
    endfunction

    task automatic respond();
        logic [N-1:0] dropped;
        dropped = '0;
        if (reset) begin
            mem_read_ready = 0; mem_write_ready = 0; wait_cnt = next_lat();
            return;
        end
        if (refill)
            for (int i = 0; i < N; i++) if (!req_read_valid[i]) req_read_valid[i] = 1;
        for (int i = 0; i < N; i++) begin
            if (req_read_valid[i] && req_read_ready[i] && (!rand_mode || $urandom % 3 != 0)) begin
                req_read_valid[i] = 0; dropped[i] = 1;
            end
            if (req_write_valid[i] && req_write_ready[i] && (!rand_mode || $urandom % 3 != 0)) begin
                req_write_valid[i] = 0; dropped[i] = 1;
            end
            if (rand_mode && int'(grant_id) == i && (mem_read_valid || mem_write_valid)) begin
                if ($urandom % 4 == 0) begin
                    req_read_address[i] = A'($urandom); req_write_address[i] = A'($urandom);
                    req_write_data[i] = D'($urandom);
                end
                if ($urandom % 16 == 0) begin
                    if (mem_read_valid) req_read_valid[i] = 0; else req_write_valid[i] = 0;
                    dropped[i] = 1;
                end
            end
            if (rand_mode && !req_read_valid[i] && !req_write_valid[i] && !dropped[i] && $urandom % 4 == 0) begin
                int kind;
                kind = int'($urandom % 3);
                req_read_address[i] = A'($urandom); req_write_address[i] = A'($urandom);
                req_write_data[i] = D'($urandom);
                req_read_valid[i] = (kind != 1);
                req_write_valid[i] = (kind != 0);
            end
        end
        if (mem_read_ready || mem_write_ready) begin
            mem_read_ready = 0; mem_write_ready = 0; wait_cnt = next_lat();
        end else if (mem_read_valid || mem_write_valid) begin
            if (wait_cnt == 0) begin
                mem_read_ready = mem_read_valid; mem_write_ready = mem_write_valid;
            end else wait_cnt--;
        end else wait_cnt = next_lat();
        if (rand_mode) mem_read_data = D'($urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        respond();
    endtask

    task automatic pulse_reset();
        reset = 1;
        req_read_valid = '0; req_write_valid = '0;
        mem_read_ready = 0; mem_write_ready = 0;
        tick(); tick();
        reset = 0;
        grants.delete();
    endtask

    task automatic wait_grants(input int n, input string name);
        int t;
        t = 0;
        while (grants.size() < n && t < 300) begin tick(); t++; end
        chk(name, grants.size() >= n, 1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((busy || |req_read_valid || |req_write_valid) && t < 300) begin tick(); t++; end
        chk("drain_idle", {busy, req_read_valid, req_write_valid}, 0);
    endtask

    initial begin
        int t;
        int exp_rr [5] = '{0, 1, 2, 3, 0};
        int exp_rw [5] = '{0, 1, 2, 3, 16};
        reset = 0;
        req_read_valid = '0; req_write_valid = '0;
        mem_read_ready = 0; mem_write_ready = 0; mem_read_data = 8'hA5;
        for (int i = 0; i < N; i++) begin
            req_read_address[i] = A'(8'h20 + i); req_write_address[i] = A'(8'h40 + i);
            req_write_data[i] = D'(8'h90 + i);
        end
        #1 reset = 1;
        tick(); tick();
        reset = 0;
        tick(); tick();
        chk("idle_busy", busy, 0);
        chk("idle_grant_id", grant_id, 0);
        chk("idle_ready", {req_read_ready, req_write_ready}, 0);

        // Single read from port 2
        req_read_address[2] = 8'h3C; req_read_valid[2] = 1;
        tick();
        chk("rd_valid_next_cycle", mem_read_valid, 1);
        chk("rd_address", mem_read_address, 8'h3C);
        chk("rd_grant_id", grant_id, 2);
        t = 0;
        while (!req_read_ready[2] && t < 20) begin tick(); t++; end
        chk("rd_ready_seen", req_read_ready[2], 1);
        chk("rd_data", req_read_data[2], 8'hA5);
        tick();
        chk("rd_ready_dropped", req_read_ready, 0);
        chk("rd_back_idle", busy, 0);
        chk("model_ptr_after_rd", m_ptr, 3);
        chk("model_rdata2", m_rdata[2], 8'hA5);

        // Single write from port 1
        req_write_address[1] = 8'h10; req_write_data[1] = 8'h77; req_write_valid[1] = 1;
        tick();
        chk("wr_valid", mem_write_valid, 1);
        chk("wr_no_read", mem_read_valid, 0);
        chk("wr_address", mem_write_address, 8'h10);
        chk("wr_data", mem_write_data, 8'h77);
        chk("wr_grant_id", grant_id, 1);
        t = 0;
        while (!req_write_ready[1] && t < 20) begin tick(); t++; end
        chk("wr_ready_seen", req_write_ready, 4'b0010);
        chk("wr_no_read_ready", req_read_ready, 0);
        tick();
        chk("wr_ready_dropped", req_write_ready, 0);

        // Round robin with all ports continuously requesting reads
        pulse_reset();
        mem_lat = 0;
        refill = 1; req_read_valid = '1;
        wait_grants(5, "rr_grants_timeout");
        refill = 0;
        for (int k = 0; k < 5; k++)
            chk($sformatf("rr_order[%0d]", k), grants.size() > k ? grants[k] : -1, exp_rr[k]);
        drain();

        // Read and write on port 0 together, others reading
        pulse_reset();
        req_read_valid = '1; req_write_valid = 4'b0001;
        wait_grants(5, "rw_grants_timeout");
        for (int k = 0; k < 5; k++)
            chk($sformatf("rw_order[%0d]", k), grants.size() > k ? grants[k] : -1, exp_rw[k]);
        drain();

        // Reset while a read waits on memory
        mem_lat = 20;
        req_read_valid[3] = 1;
        t = 0;
        while (!mem_read_valid && t < 20) begin tick(); t++; end
        chk("mid_grant_id", grant_id, 3);
        tick();
        reset = 1;
        #1;
        chk("mid_rst_read_valid", mem_read_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_grant_id", grant_id, 0);
        req_read_valid = '0;
        tick();
        reset = 0;
        grants.delete();
        mem_lat = 1;
        req_read_valid = 4'b1001;
        wait_grants(2, "mid_grants_timeout");
        chk("mid_first_grant", grants.size() > 0 ? grants[0] : -1, 0);
        chk("mid_second_grant", grants.size() > 1 ? grants[1] : -1, 3);
        drain();

        // Random traffic
        rand_mode = 1;
        repeat (3000) tick();
        rand_mode = 0;
        mem_lat = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
